// File: rtl/mdu_pkg.sv
// Shared types and helpers for the multiply/divide unit that owns HI/LO.
package mdu_pkg;

  localparam int MDU_W = 32;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } mdu_state_t;

  // True for the ops that occupy the unit for more than the issue cycle.
  function automatic logic is_iter_op(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

  // Two's-complement negate when n is set.
  function automatic logic [MDU_W-1:0] cond_neg(input logic [MDU_W-1:0] v,
                                                input logic n);
    return n ? -v : v;
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Restoring divider on unsigned magnitudes: one quotient bit per step.
// The remainder register shifts in dividend bits from the quotient register,
// so after DIV_CYCLES steps quot holds the quotient and rem the remainder.
module mdu_div_core
  import mdu_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [MDU_W-1:0] dividend,
  input  logic [MDU_W-1:0] divisor,
  output logic [MDU_W-1:0] quot,
  output logic [MDU_W-1:0] rem,
  output logic             done
);

  localparam int CW = $clog2(DIV_CYCLES);

  logic [MDU_W-1:0] rem_q, rem_d;
  logic [MDU_W-1:0] quo_q, quo_d;
  logic [MDU_W-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [MDU_W:0]   trial;

  // Next-state for one restoring step: shift, trial-subtract, keep or restore.
  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    cnt_d = cnt_q;
    trial = {rem_q, quo_q[MDU_W-1]};
    if (load) begin
      rem_d = '0;
      quo_d = dividend;
      dvs_d = divisor;
      cnt_d = '0;
    end else if (step) begin
      if (trial >= {1'b0, dvs_q}) begin
        rem_d = MDU_W'(trial - {1'b0, dvs_q});
        quo_d = {quo_q[MDU_W-2:0], 1'b1};
      end else begin
        rem_d = trial[MDU_W-1:0];
        quo_d = {quo_q[MDU_W-2:0], 1'b0};
      end
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Step counter is control state and is reset.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // Datapath registers carry no reset; they are always loaded before use.
  always_ff @(posedge clk) begin
    rem_q <= rem_d;
    quo_q <= quo_d;
    dvs_q <= dvs_d;
  end

  assign done = step && (cnt_q == CW'(DIV_CYCLES - 1));
  assign quot = quo_q;
  assign rem  = rem_q;

endmodule

// File: rtl/mdu_hilo.sv
// Multi-cycle multiply/divide unit holding the HI/LO registers.
// Build option MDU_FAST_MUL_EN: MULT/MULTU use a single-cycle 33x33 signed
// multiply (IDLE->FIX->IDLE); otherwise a 32-step shift-add multiplier.
module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             ex_adv,
  input  logic [2:0]       op,
  input  logic [MDU_W-1:0] a,
  input  logic [MDU_W-1:0] b,
  input  logic             flush,
  output logic [MDU_W-1:0] hi,
  output logic [MDU_W-1:0] lo,
  output logic             isbusy
);

  localparam int            CW   = $clog2(DIV_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DIV_CYCLES - 1);

  mdu_state_t         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [MDU_W-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               neg_q, neg_d;    // negate product / quotient
  logic               rneg_q, rneg_d;  // negate remainder
  logic               isdiv_q, isdiv_d;
  logic [2*MDU_W-1:0] acc_q, acc_d, mcd_q, mcd_d;
  logic [MDU_W-1:0]   mpl_q, mpl_d;

  logic               accept, signed_op, a_neg, b_neg;
  logic [MDU_W-1:0]   a_mag, b_mag;
  logic               div_load, div_step, div_done;
  logic [MDU_W-1:0]   div_quot, div_rem;
`ifdef MDU_FAST_MUL_EN
  logic signed [MDU_W:0]     fa, fb;
  logic signed [2*MDU_W+1:0] fprod;
`endif

  mdu_div_core #(.DIV_CYCLES(DIV_CYCLES)) u_div (
    .clk      (clk),
    .rst      (rst),
    .load     (div_load),
    .step     (div_step),
    .dividend (a_mag),
    .divisor  (b_mag),
    .quot     (div_quot),
    .rem      (div_rem),
    .done     (div_done)
  );

  // Operand sign/magnitude split and acceptance qualification.
  always_comb begin
    signed_op = (op == MDU_MULT) || (op == MDU_DIV);
    a_neg     = signed_op & a[MDU_W-1];
    b_neg     = signed_op & b[MDU_W-1];
    a_mag     = cond_neg(a, a_neg);
    b_mag     = cond_neg(b, b_neg);
    accept    = start & ex_adv & ~flush & (state_q == ST_IDLE);
    div_load  = accept & ((op == MDU_DIV) || (op == MDU_DIVU));
    div_step  = (state_q == ST_DIV);
`ifdef MDU_FAST_MUL_EN
    fa        = {signed_op & a[MDU_W-1], a};
    fb        = {signed_op & b[MDU_W-1], b};
    fprod     = fa * fb;
`endif
  end

  // Sequencer next state, multiply iteration and the final HI/LO write.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    isdiv_d = isdiv_q;
    acc_d   = acc_q;
    mcd_d   = mcd_q;
    mpl_d   = mpl_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (op)
            MDU_MULT, MDU_MULTU: begin
              isdiv_d = 1'b0;
`ifdef MDU_FAST_MUL_EN
              acc_d   = fprod[2*MDU_W-1:0];
              neg_d   = 1'b0;
              state_d = ST_FIX;
`else
              acc_d   = '0;
              mcd_d   = {{MDU_W{1'b0}}, a_mag};
              mpl_d   = b_mag;
              neg_d   = a_neg ^ b_neg;
              state_d = ST_MUL;
`endif
            end
            MDU_DIV, MDU_DIVU: begin
              isdiv_d = 1'b1;
              neg_d   = a_neg ^ b_neg;
              rneg_d  = a_neg;
              state_d = ST_DIV;
            end
            MDU_MTHI: hi_d = a;
            MDU_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      ST_MUL, ST_DIV: begin
        if (state_q == ST_MUL) begin
          if (mpl_q[0]) acc_d = acc_q + mcd_q;
          mcd_d = mcd_q << 1;
          mpl_d = mpl_q >> 1;
        end
        cnt_d = cnt_q + CW'(1);
        if (((state_q == ST_MUL) && (cnt_q == LAST)) ||
            ((state_q == ST_DIV) && div_done)) begin
          cnt_d   = '0;
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        if (isdiv_q) begin
          lo_d = cond_neg(div_quot, neg_q);
          hi_d = cond_neg(div_rem, rneg_q);
        end else begin
          {hi_d, lo_d} = neg_q ? (-acc_q) : acc_q;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  // Control state and architectural HI/LO, synchronously reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      isdiv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      isdiv_q <= isdiv_d;
    end
  end

  // Multiplier datapath registers; loaded at acceptance, no reset needed.
  always_ff @(posedge clk) begin
    acc_q <= acc_d;
    mcd_q <= mcd_d;
    mpl_q <= mpl_d;
  end

  // Combinational so a HI/LO reader in ID stalls in the issue cycle itself.
  assign isbusy = (state_q != ST_IDLE) | (start & is_iter_op(op));
  assign hi     = hi_q;
  assign lo     = lo_q;

endmodule

// File: doc/mdu_hilo.md
# mdu_hilo

Multi-cycle multiply/divide unit that owns the HI/LO architectural registers. It sits beside the EX stage and is fed by the EX-stage operand bypass muxes. It produces the `isbusy` flag consumed by the pipeline stall logic, which holds any HI/LO reader in ID while an operation is in flight. MULT/MULTU/DIV/DIVU run iteratively; MTHI/MTLO write in one cycle.

## Interface
Parameters:
- `DIV_CYCLES`, 32: iteration count of the divider; also the multiply iteration count when the fast-multiply option is absent. Fixed at 32 for 32-bit operands.

Ports:
- `clk` in 1: pipeline clock. One clock; all state updates on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: an MDU instruction is in EX.
- `ex_adv` in 1: EX→MEM1 register writes this cycle (EX_MEM1Wr).
- `op` in 3: MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI or MDU_MTLO.
- `a` in 32: rs operand, post-bypass.
- `b` in 32: rt operand, post-bypass.
- `flush` in 1: discard the in-flight MDU operation (MEM1 exception or eret flush).
- `hi` out 32: HI register.
- `lo` out 32: LO register.
- `isbusy` out 1: an operation is in flight or being issued; HI/LO are not yet valid.

## Operation
- Acceptance: an op is accepted only when `start & ex_adv & ~flush & state==IDLE`. While EX is held, `start` has no effect, so each instruction is accepted exactly once.
- MTHI/MTLO on acceptance: `hi` (or `lo`) ← `a` at the next edge. The state stays IDLE.
- FSM states: IDLE, MUL, DIV, FIX.
  - IDLE→MUL on accepted MULT/MULTU.
  - IDLE→DIV on accepted DIV/DIVU.
  - MUL/DIV→FIX when the iteration counter reaches `DIV_CYCLES-1`.
  - FIX→IDLE, writing `hi`/`lo`.
- Signed ops work on operand magnitudes; the operand signs are latched at acceptance.
- FIX applies sign correction:
  - Product: negate the 64-bit result if sign(a)^sign(b).
  - Quotient: negate if sign(a)^sign(b).
  - Remainder: takes the sign of `a`.
- Multiply (iterative): shift-add over a 64-bit accumulator, one multiplier bit per cycle. Result: `{hi,lo}` = 64-bit product.
- Divide: restoring division, one quotient bit per cycle, using a 33-bit partial remainder. Result: `lo` = quotient, `hi` = remainder.
- Divide by zero: no trap; the algorithm runs its full length.
  - DIVU x/0: `lo`=32'hFFFF_FFFF, `hi`=x.
  - DIV x/0 with x≥0: `lo`=32'hFFFF_FFFF, `hi`=x.
  - DIV x/0 with x<0: `lo`=1, `hi`=x.
- DIV 32'h8000_0000 / -1: `lo`=32'h8000_0000, `hi`=0.
- `isbusy` = `(state!=IDLE) | (start & (op is MULT/MULTU/DIV/DIVU))`. It is combinational so that a HI/LO reader in ID behind an MDU op in EX stalls in the same cycle.
- `flush` in any state: the next state is IDLE, the counter is cleared, and `hi`/`lo` keep their prior values. A simultaneous `start` is ignored.
- A `start` arriving while the state is not IDLE is ignored. This cannot occur legally because the stall logic holds HI/LO users; MDU ops are themselves HI/LO writers.

## Timing
- Reset values: `hi`=0, `lo`=0, state=IDLE, counter=0, `isbusy`=`start`-term only (0 with `start`=0).
- Accept at edge E0. Iterations occupy cycles E0+1 … E0+32. FIX occupies cycle E0+33. `hi`/`lo` hold the new values after edge E0+34. `isbusy` deasserts in the cycle after FIX.
- MTHI/MTLO: the value is visible one cycle after the accepting edge, and `isbusy` is never asserted for them.
- `rst` mid-operation: the unit returns to reset values at the next edge.

## Configuration
- `MDU_FAST_MUL_EN` defined: MULT/MULTU use a single-cycle 33×33 signed multiply. The path is IDLE→FIX→IDLE, so the result is visible after edge E0+2.
- `MDU_FAST_MUL_EN` undefined: the 32-iteration shift-add path described above.
- Divide timing is identical in both builds.

## Structure
- Shared package `mdu_pkg`:
  - `mdu_op_t` encodings: MDU_MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5.
  - `mdu_state_t`.
  - `MDU_W=32`.
- Sub-module `mdu_div_core`: one restoring-divide step per cycle, with load, step and done signals. It is instantiated once; the FSM, sign handling and HI/LO registers stay at top level.

## Test plan
- DIVU 100/7, no flush → `isbusy` high for 34 cycles from the start cycle; then `lo`=14, `hi`=2.
- DIV -7/2 → `lo`=32'hFFFF_FFFD (-3), `hi`=32'hFFFF_FFFF (-1); MULT -3×5 → `{hi,lo}`=64'hFFFF_FFFF_FFFF_FFF1.
- MULTU FFFF_FFFF×FFFF_FFFF → `hi`=FFFF_FFFE, `lo`=1. Run once with and once without `MDU_FAST_MUL_EN`, checking result latency of 2 vs 34.
- DIV 5/0 → `lo`=FFFF_FFFF, `hi`=5; DIV 32'h8000_0000/-1 → `lo`=8000_0000, `hi`=0.
- Start with `ex_adv`=0 for 3 cycles, then `ex_adv`=1 → exactly one operation; `isbusy` high throughout the hold.
- MTLO 0x1234 sets `lo`; then DIV accepted, then `flush` at iteration 10 → IDLE next cycle, `lo`=0x1234 kept, `isbusy`=0.
